snapshot_trig: RTL and testbench

SNAPSHOT_TRIG -- requirements
Module: snapshot_trig

---
 rtl/snapshot_trig.sv | 136 +++++++++++++
 tb/tb_snapshot_trig.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/snapshot_trig.sv
// Triggered snapshot buffer: records samples into a circular memory around a
// qualified trigger, then freezes for readback with logical index 0 = oldest word.
module snapshot_trig #(
  parameter int SWidth = 8,
  parameter int Depth  = 64,
  parameter int AWidth = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              en,
  input  logic [SWidth-1:0] data_in,
  input  logic              trigger,
  input  logic [AWidth:0]   post_len,
  input  logic [AWidth-1:0] rd_addr,
  output logic [SWidth-1:0] rd_data,
  output logic [1:0]        state,
  output logic              done,
  output logic [AWidth-1:0] trig_addr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [AWidth:0] DEPTH_W = (AWidth+1)'(Depth);
  localparam logic [AWidth:0] ONE_W   = (AWidth+1)'(1);

  function automatic logic [AWidth:0] clamp_len(input logic [AWidth:0] len);
    if (len == '0)
      return ONE_W;
    else if (len > DEPTH_W)
      return DEPTH_W;
    else
      return len;
  endfunction

  function automatic logic [AWidth:0] sat_inc(input logic [AWidth:0] cnt);
    return (cnt >= DEPTH_W) ? DEPTH_W : cnt + ONE_W;
  endfunction

  state_t              state_q, state_nxt;
  logic [AWidth-1:0]   wr_ptr;
  logic [AWidth:0]     pre_cnt, pre_nxt;
  logic [AWidth:0]     rem_cnt, rem_nxt;
  logic [AWidth:0]     len_q, len_nxt;
  logic [AWidth-1:0]   trig_q, trig_nxt;
  logic                wr_en_p0;
  logic                pre_ok;
  logic [AWidth-1:0]   rd_phys_p0;
  logic [SWidth-1:0]   rd_data_p1;
  logic [SWidth-1:0]   mem [Depth];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wr_ptr  <= '0;
      pre_cnt <= '0;
      rem_cnt <= '0;
      len_q   <= ONE_W;
      trig_q  <= '0;
    end else begin
      state_q <= state_nxt;
      pre_cnt <= pre_nxt;
      rem_cnt <= rem_nxt;
      len_q   <= len_nxt;
      trig_q  <= trig_nxt;
      if (wr_en_p0)
        wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // pre_ok uses the count before this cycle's write, so the trigger sample
  // itself is not counted as history.
  always_comb begin
    state_nxt = state_q;
    wr_en_p0  = 1'b0;
    pre_nxt   = pre_cnt;
    rem_nxt   = rem_cnt;
    len_nxt   = len_q;
    trig_nxt  = trig_q;
    pre_ok    = (pre_cnt >= (DEPTH_W - len_q));
    if (arm) begin
      state_nxt = ARMED;
      pre_nxt   = '0;
      len_nxt   = clamp_len(post_len);
    end else begin
      case (state_q)
        ARMED: begin
          if (en) begin
            wr_en_p0 = 1'b1;
            pre_nxt  = sat_inc(pre_cnt);
            if (trigger && pre_ok) begin
              trig_nxt  = wr_ptr;
              rem_nxt   = len_q - ONE_W;
              state_nxt = (len_q == ONE_W) ? DONE : POST;
            end
          end
        end
        POST: begin
          if (en) begin
            wr_en_p0 = 1'b1;
            rem_nxt  = rem_cnt - ONE_W;
            if (rem_cnt == ONE_W)
              state_nxt = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_p0)
      mem[wr_ptr] <= data_in;
  end

  // ---- read stage p0 -> p1: logical index rebased on the write pointer
  assign rd_phys_p0 = wr_ptr + rd_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rd_data_p1 <= '0;
    else
      rd_data_p1 <= mem[rd_phys_p0];
  end

  assign rd_data   = rd_data_p1;
  assign state     = state_q;
  assign done      = (state_q == DONE);
  assign trig_addr = trig_q;

endmodule

// File: tb/tb_snapshot_trig.sv
// Directed bench for snapshot_trig at Depth=8: table-driven main capture plus
// hand-written multi-cycle corner sequences.
module tb_snapshot_trig;

  logic       clk = 1'b0;
  logic       reset, arm, en, trigger;
  logic [7:0] data_in;
  logic [3:0] post_len;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;
  logic [1:0] state;
  logic       done;
  logic [2:0] trig_addr;

  int checks   = 0;
  int failures = 0;
  int cnt      = 0;

  typedef struct {
    logic       trg;
    logic [1:0] exp_state;
    logic       exp_done;
  } vec_t;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] exp;
  } rd_t;

  vec_t va[13];
  rd_t  ra[8];

  snapshot_trig #(.SWidth(8), .Depth(8), .AWidth(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .arm       (arm),
    .en        (en),
    .data_in   (data_in),
    .trigger   (trigger),
    .post_len  (post_len),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .state     (state),
    .done      (done),
    .trig_addr (trig_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input int pl);
    arm = 1'b1; en = 1'b0; trigger = 1'b0; post_len = 4'(pl);
    tick();
    arm = 1'b0;
    cnt = 0;
  endtask

  task automatic sample(input logic trg);
    en = 1'b1; trigger = trg; data_in = 8'(cnt);
    tick();
    en = 1'b0; trigger = 1'b0;
    cnt++;
  endtask

  task automatic readback(input int base, input string tag);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      tick();
      chk($sformatf("%s_rd%0d", tag, i), rd_data, (base + i) % 256);
    end
  endtask

  task automatic run_a(input string tag);
    do_arm(3);
    chk({tag, "_armed"}, state, 1);
    for (int i = 0; i < 13; i++) begin
      sample(va[i].trg);
      chk($sformatf("%s_state%0d", tag, i), state, va[i].exp_state);
      chk($sformatf("%s_done%0d", tag, i), done, va[i].exp_done);
    end
    chk({tag, "_trig_addr"}, trig_addr, 2);
    for (int i = 0; i < 8; i++) begin
      rd_addr = ra[i].addr;
      tick();
      chk($sformatf("%s_rd%0d", tag, i), rd_data, ra[i].exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 13; i++) begin
      va[i].trg       = (i == 10);
      va[i].exp_state = (i < 10) ? 2'd1 : (i < 12) ? 2'd2 : 2'd3;
      va[i].exp_done  = (i == 12);
    end
    for (int i = 0; i < 8; i++) begin
      ra[i].addr = 3'(i);
      ra[i].exp  = 8'(5 + i);
    end

    reset = 1'b1; arm = 1'b0; en = 1'b0; trigger = 1'b0;
    data_in = '0; post_len = 4'd1; rd_addr = '0;
    tick(); tick();
    chk("rst_state", state, 0);
    chk("rst_done", done, 0);
    chk("rst_trig_addr", trig_addr, 0);
    chk("rst_rd_data", rd_data, 0);
    reset = 1'b0;
    tick();
    chk("idle_state", state, 0);

    // Main capture: trigger on sample 10, post_len=3
    run_a("A");

    // Early trigger ignored until pre-count reaches Depth-post_len
    do_arm(3);
    sample(0); sample(0);
    sample(1);
    chk("B_early_trig", state, 1);
    sample(0); sample(0); sample(0);
    sample(1);
    chk("B_accept", state, 2);
    chk("B_trig_addr", trig_addr, 3);
    sample(0); sample(0);
    chk("B_done", done, 1);
    readback(1, "B");

    // en gaps between post samples do not count
    do_arm(3);
    for (int i = 0; i < 5; i++) sample(0);
    sample(1);
    chk("C_post", state, 2);
    sample(0);
    chk("C_post2_done", done, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("C_gap%0d_state", i), state, 2);
      chk($sformatf("C_gap%0d_done", i), done, 0);
    end
    sample(0);
    chk("C_final_done", done, 1);
    chk("C_final_state", state, 3);

    // post_len = Depth: immediate trigger accepted
    do_arm(8);
    sample(1);
    chk("D_accept", state, 2);
    for (int i = 1; i < 7; i++) sample(0);
    chk("D_before_last", state, 2);
    sample(0);
    chk("D_done", state, 3);
    readback(0, "D");

    // arm while DONE, simultaneous with en: sample dropped, buffer kept
    arm = 1'b1; en = 1'b1; data_in = 8'hAA; post_len = 4'd8;
    tick();
    arm = 1'b0; en = 1'b0;
    chk("E_state", state, 1);
    chk("E_done", done, 0);
    readback(0, "E");

    // post_len=0 treated as 1: needs 7 history words, goes straight to DONE
    do_arm(0);
    for (int i = 0; i < 6; i++) sample(0);
    sample(1);
    chk("L0_early", state, 1);
    sample(1);
    chk("L0_done", state, 3);

    // post_len above Depth clamps to Depth
    do_arm(15);
    sample(1);
    chk("CLAMP_accept", state, 2);

    // Reset during POST aborts; a fresh capture matches the first one
    do_arm(3);
    for (int i = 0; i < 5; i++) sample(0);
    sample(1);
    chk("F_post", state, 2);
    #2;
    reset = 1'b1;
    #1;
    chk("F_rst_state", state, 0);
    chk("F_rst_done", done, 0);
    chk("F_rst_trig_addr", trig_addr, 0);
    chk("F_rst_rd_data", rd_data, 0);
    tick();
    reset = 1'b0;
    tick();
    run_a("F");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
